// File: rtl/counter_pkg.sv
// Shared definitions for the programmable counter: FSM states, mode and
// direction encodings.
package counter_pkg;

    // Controller states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // mode input encoding
    localparam logic MODE_FREE    = 1'b0;
    localparam logic MODE_ONESHOT = 1'b1;

    // up_down input encoding
    localparam logic DIR_DOWN = 1'b0;
    localparam logic DIR_UP   = 1'b1;

endpackage

// File: rtl/counter_step.sv
// Combinational next-value generator for the programmable counter.
// Produces the value one step away from count (wrapping within 0..modulus)
// and flags whether count currently sits on the terminal value for the
// selected direction. Out-of-range counts (count > modulus) are folded back
// into range without being treated as terminal.
module counter_step
    import counter_pkg::*;
#(
    parameter int BIT_SZ = 16
) (
    input  logic [BIT_SZ-1:0] count,
    input  logic [BIT_SZ-1:0] modulus,
    input  logic              up_down,
    output logic [BIT_SZ-1:0] next_count,
    output logic              terminal
);

    localparam logic [BIT_SZ-1:0] ONE  = {{(BIT_SZ-1){1'b0}}, 1'b1};
    localparam logic [BIT_SZ-1:0] ZERO = '0;

    // Next value and terminal flag for one step in the requested direction
    always_comb begin
        next_count = ZERO;
        terminal   = 1'b0;
        if (up_down == DIR_UP) begin
            terminal = (count == modulus);
            if (count >= modulus) begin
                next_count = ZERO;
            end else begin
                next_count = count + ONE;
            end
        end else begin
            terminal = (count == ZERO);
            if ((count == ZERO) || (count > modulus)) begin
                next_count = modulus;
            end else begin
                next_count = count - ONE;
            end
        end
    end

endmodule

// File: rtl/counter_prog.sv
// Programmable up/down counter with free-run and one-shot modes.
// Owns the count register, the terminal-count pulse and the IDLE/RUN/DONE
// controller; the arithmetic of a single step lives in counter_step.
// Edge priority: reset > load > start > enabled step.
module counter_prog
    import counter_pkg::*;
#(
    parameter int BIT_SZ = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic              start,
    input  logic              load,
    input  logic [BIT_SZ-1:0] load_value,
    input  logic              up_down,
    input  logic [BIT_SZ-1:0] modulus,
    input  logic              mode,
    output logic [BIT_SZ-1:0] count,
    output logic              tc,
    output logic              busy
);

    state_t            state;
    logic [BIT_SZ-1:0] step_next;
    logic              step_terminal;
    logic              start_accept;
    logic [BIT_SZ-1:0] init_value;

    counter_step #(
        .BIT_SZ (BIT_SZ)
    ) u_step (
        .count      (count),
        .modulus    (modulus),
        .up_down    (up_down),
        .next_count (step_next),
        .terminal   (step_terminal)
    );

    // start only has effect from IDLE or DONE; a fresh run begins at the
    // end of the range opposite to the terminal value
    assign start_accept = start && (state != RUN);
    assign init_value   = (up_down == DIR_UP) ? '0 : modulus;

    // Controller, count register and registered tc/busy outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            count <= '0;
            tc    <= 1'b0;
            busy  <= 1'b0;
        end else begin
            tc <= 1'b0;
            if (load) begin
                // load wins over start's reinitialisation but still lets
                // start launch a run from IDLE/DONE
                count <= load_value;
                if (start_accept) begin
                    state <= RUN;
                    busy  <= 1'b1;
                end
            end else if (start_accept) begin
                state <= RUN;
                busy  <= 1'b1;
                count <= init_value;
            end else if ((state == RUN) && enable) begin
                if (step_terminal) begin
                    tc <= 1'b1;
                    if (mode == MODE_ONESHOT) begin
                        // count already equals the terminal value: hold it
                        state <= DONE;
                        busy  <= 1'b0;
                    end else begin
                        count <= step_next;
                    end
                end else begin
                    count <= step_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_counter_prog.sv
// Directed testbench for counter_prog (BIT_SZ=4) with a behavioural model
// checked every cycle plus hand-computed literal expectations.
module tb_counter_prog;

    localparam int W = 4;

    logic         clock = 1'b0;
    logic         reset;
    logic         enable;
    logic         start;
    logic         load;
    logic [W-1:0] load_value;
    logic         up_down;
    logic [W-1:0] modulus;
    logic         mode;
    logic [W-1:0] count;
    logic         tc;
    logic         busy;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    counter_prog #(
        .BIT_SZ (W)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .start      (start),
        .load       (load),
        .load_value (load_value),
        .up_down    (up_down),
        .modulus    (modulus),
        .mode       (mode),
        .count      (count),
        .tc         (tc),
        .busy       (busy)
    );

    // ---------------- behavioural model ----------------
    // st: 0 idle, 1 running, 2 finished
    typedef struct {
        int cnt;
        int st;
        bit tc;
    } mst_t;

    mst_t m;
    bit   mvalid = 1'b0;

    function automatic mst_t model_next(mst_t s, bit rst, bit en, bit st_req,
                                        bit ld, int lv, bit ud, int md, bit oneshot);
        mst_t n;
        bit   term;
        int   wrapped;
        n    = s;
        n.tc = 1'b0;
        if (rst) begin
            n.cnt = 0;
            n.st  = 0;
        end else if (ld) begin
            n.cnt = lv;
            if (st_req && s.st != 1) n.st = 1;
        end else if (st_req && s.st != 1) begin
            n.st  = 1;
            n.cnt = ud ? 0 : md;
        end else if (s.st == 1 && en) begin
            term = ud ? (s.cnt == md) : (s.cnt == 0);
            if (ud) wrapped = (s.cnt >= md) ? 0 : s.cnt + 1;
            else    wrapped = (s.cnt == 0 || s.cnt > md) ? md : s.cnt - 1;
            if (term) n.tc = 1'b1;
            if (term && oneshot) n.st = 2;
            else                 n.cnt = wrapped;
        end
        return n;
    endfunction

    always @(posedge clock) begin
        m <= model_next(m, reset, enable, start, load, int'(load_value),
                        up_down, int'(modulus), mode);
        if (reset) mvalid <= 1'b1;
    end

    // ---------------- literal expectations mailbox ----------------
    int    lit_seq = 0;
    string lit_name;
    int    lit_c;
    bit    lit_t;
    bit    lit_b;

    task automatic chk(string nm, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Single compare process: model every cycle, literals when posted
    initial begin
        int lit_done;
        lit_done = 0;
        forever begin
            @(negedge clock);
            if (mvalid) begin
                chk("model_count", int'(count), m.cnt);
                chk("model_tc", int'(tc), int'(m.tc));
                chk("model_busy", int'(busy), (m.st == 1) ? 1 : 0);
            end
            if (lit_done != lit_seq) begin
                lit_done = lit_seq;
                chk({lit_name, "/count"}, int'(count), lit_c);
                chk({lit_name, "/tc"}, int'(tc), int'(lit_t));
                chk({lit_name, "/busy"}, int'(busy), int'(lit_b));
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic lit(string nm, int c, bit t, bit b);
        lit_name = nm;
        lit_c    = c;
        lit_t    = t;
        lit_b    = b;
        lit_seq++;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        int fr_c[7];
        bit fr_t[7];
        int os_c[5];
        bit os_t[5];
        bit os_b[5];
        int ou_c[4];
        bit ou_t[4];
        bit ou_b[4];

        fr_c = '{1, 2, 3, 4, 5, 0, 1};
        fr_t = '{0, 0, 0, 0, 0, 1, 0};
        os_c = '{2, 1, 0, 0, 0};
        os_t = '{0, 0, 0, 1, 0};
        os_b = '{1, 1, 1, 0, 0};
        ou_c = '{1, 2, 2, 2};
        ou_t = '{0, 0, 1, 0};
        ou_b = '{1, 1, 0, 0};

        reset = 1'b1; enable = 1'b0; start = 1'b0; load = 1'b0;
        load_value = '0; up_down = 1'b1; modulus = 4'd5; mode = 1'b0;
        tick();
        tick();
        lit("reset", 0, 0, 0);

        // Free-run up, modulus 5; enable alone in IDLE does nothing
        reset = 1'b0; enable = 1'b1;
        tick(); lit("idle_hold", 0, 0, 0);
        start = 1'b1;
        tick(); lit("fr_start", 0, 0, 1);
        start = 1'b0;
        for (int i = 0; i < 7; i++) begin
            tick(); lit($sformatf("fr_up_%0d", i), fr_c[i], fr_t[i], 1);
        end
        start = 1'b1;
        tick(); lit("start_in_run", 2, 0, 1);
        start = 1'b0; enable = 1'b0;
        tick(); lit("run_no_enable", 2, 0, 1);

        // One-shot down, modulus 3, then restart from DONE
        do_reset();
        modulus = 4'd3; mode = 1'b1; up_down = 1'b0; enable = 1'b1; start = 1'b1;
        tick(); lit("os_start", 3, 0, 1);
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick(); lit($sformatf("os_dn_%0d", i), os_c[i], os_t[i], os_b[i]);
        end
        start = 1'b1;
        tick(); lit("os_restart", 3, 0, 1);
        start = 1'b0;

        // Load priority over enable
        do_reset();
        modulus = 4'd15; mode = 1'b0; up_down = 1'b1; start = 1'b1; enable = 1'b0;
        tick(); lit("ld_start", 0, 0, 1);
        start = 1'b0; load = 1'b1; load_value = 4'd7;
        tick(); lit("ld_7", 7, 0, 1);
        load_value = 4'd12; enable = 1'b1;
        tick(); lit("ld_prio", 12, 0, 1);
        load = 1'b0;
        tick(); lit("ld_next", 13, 0, 1);

        // Out-of-range count folds back without tc
        modulus = 4'd4; load = 1'b1; load_value = 4'd9;
        tick(); lit("oor_ld_a", 9, 0, 1);
        load = 1'b0;
        tick(); lit("oor_up", 0, 0, 1);
        load = 1'b1;
        tick(); lit("oor_ld_b", 9, 0, 1);
        load = 1'b0; up_down = 1'b0;
        tick(); lit("oor_dn", 4, 0, 1);

        // load + start together from IDLE
        do_reset();
        load = 1'b1; start = 1'b1; load_value = 4'd10;
        tick(); lit("ld_start_idle", 10, 0, 1);
        load = 1'b0; start = 1'b0;
        tick(); lit("ld_start_step", 4, 0, 1);

        // Reset mid-run aborts; enable alone afterwards keeps count at 0
        do_reset();
        modulus = 4'd15; mode = 1'b0; up_down = 1'b1; enable = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        lit("rm_6", 6, 0, 1);
        reset = 1'b1;
        tick(); lit("rm_reset", 0, 0, 0);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(); lit($sformatf("rm_idle_%0d", i), 0, 0, 0);
        end
        start = 1'b1;
        tick(); lit("rm_restart", 0, 0, 1);
        start = 1'b0;
        tick(); lit("rm_step", 1, 0, 1);

        // modulus 0: every enabled step is terminal
        do_reset();
        modulus = 4'd0; start = 1'b1;
        tick(); lit("m0_start", 0, 0, 1);
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(); lit($sformatf("m0_%0d", i), 0, 1, 1);
        end

        // One-shot up holds modulus in DONE
        do_reset();
        modulus = 4'd2; mode = 1'b1; up_down = 1'b1; start = 1'b1;
        tick(); lit("ou_start", 0, 0, 1);
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick(); lit($sformatf("ou_%0d", i), ou_c[i], ou_t[i], ou_b[i]);
        end

        enable = 1'b0;
        tick();
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/counter_prog.md
COUNTER_PROG -- requirements
Module: counter_prog

Interface
REQ-001 Parameter: BIT_SZ, default 16, counter width in bits (legal range 2..32).
REQ-002 Port: clock  input  1  rising-edge clock for all state.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: enable  input  1  advance count by one step in RUN when high.
REQ-005 Port: start  input  1  single-cycle request; IDLE/DONE -> RUN with count reinitialised.
REQ-006 Port: load  input  1  parallel load of load_value.
REQ-007 Port: load_value  input  BIT_SZ  value written to count on load.
REQ-008 Port: up_down  input  1  1 = count up, 0 = count down; sampled every cycle.
REQ-009 Port: modulus  input  BIT_SZ  upper bound; count range 0..modulus inclusive.
REQ-010 Port: mode  input  1  0 = free-run, 1 = one-shot; sampled every cycle.
REQ-011 Port: count  output  BIT_SZ  registered current count.
REQ-012 Port: tc  output  1  registered one-cycle terminal-count pulse.
REQ-013 Port: busy  output  1  high exactly while the state is RUN.

Function
REQ-014 State machine SHALL have states IDLE, RUN, DONE; all outputs registered, no combinational input-to-output paths.
REQ-015 Terminal value SHALL be modulus when up_down=1, and 0 when up_down=0.
REQ-016 Step in RUN with enable=1 SHALL be: up -> count+1, or 0 when count >= modulus; down -> count-1, or modulus when count == 0 or count > modulus.
REQ-017 Terminal event SHALL be an enabled step in RUN while count equals the terminal value.
REQ-018 Free-run (mode=0): on a terminal event count wraps per REQ-016, state stays RUN, tc=1 on that same edge.
REQ-019 One-shot (mode=1): on a terminal event count holds the terminal value, state RUN -> DONE, tc=1 on that same edge.
REQ-020 tc SHALL be high for exactly one cycle per terminal event; it is 0 at all other times.
REQ-021 start in IDLE or DONE SHALL set state RUN and count to 0 (up) or modulus (down); start in RUN is ignored.
REQ-022 load SHALL set count=load_value in any state, leave state unchanged and never raise tc; load has priority over enable.
REQ-023 load and start in the same cycle from IDLE/DONE SHALL give count=load_value and state RUN.
REQ-024 In IDLE and DONE, count SHALL hold its value regardless of enable.
REQ-025 modulus=0 SHALL hold count at 0 in RUN, with every enabled step a terminal event.
REQ-026 Priority per edge SHALL be: reset > load > start > enabled step.

Reset
REQ-027 reset SHALL set count=0, tc=0, busy=0 and state IDLE on the next rising edge, overriding all other inputs.
REQ-028 reset asserted mid-RUN SHALL abort the run with no tc pulse on that edge.

Structure
REQ-029 A shared package counter_pkg SHALL hold the state enumeration (IDLE, RUN, DONE) and the mode constants MODE_FREE=0 and MODE_ONESHOT=1.
REQ-030 A combinational sub-module counter_step SHALL compute the next value and the terminal flag from count, modulus and up_down; counter_prog owns the registers and the state machine.

Verification (BIT_SZ=4)
REQ-031 Free-run up: modulus=5, start, enable=1 -> count 0,1,2,3,4,5,0,1; tc high on the edge count 5 -> 0 only; busy=1 throughout.
REQ-032 One-shot down: modulus=3, mode=1, up_down=0, start, enable=1 -> count 3,2,1,0,0; tc one pulse on edge into DONE; busy 0 after; second start -> count 3, busy 1.
REQ-033 Load priority: in RUN at count 7, load=1, load_value=12, enable=1, modulus=15 -> count 12, tc 0; next enabled step -> 13.
REQ-034 Out-of-range: count loaded to 9, modulus=4, up -> next count 0 with tc 0; down from 9 -> next count 4 with tc 0.
REQ-035 Reset mid-run: free-run, modulus=15, reset at count 6 with enable=1 -> count 0, busy 0, tc 0; enable alone -> count stays 0 until start.
REQ-036 modulus=0 up, enable=1 for 3 cycles in free-run -> count stays 0, tc high every cycle.
